// File: rtl/mem_handshake_ctrl_if.sv
// rtl/mem_handshake_ctrl_if.sv - core-op and memory handshake bundle for mem_handshake_ctrl
interface mem_handshake_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic                  op_valid;
  logic                  op_ready;
  logic                  op_write;
  logic [1:0]            op_size;
  logic                  op_unsigned;
  logic [ADDR_W-1:0]     op_addr;
  logic [DATA_W-1:0]     op_wdata;
  logic                  done;
  logic                  err;
  logic [DATA_W-1:0]     rdata;
  logic [ADDR_W-1:0]     Address;
  logic                  MemWrite;
  logic                  MemRead;
  logic [DATA_W-1:0]     Write_data;
  logic [DATA_W/8-1:0]   Write_strb;
  logic                  Mem_Req_Ack;
  logic [DATA_W-1:0]     Read_data;
  logic                  Read_data_Valid;
  logic                  Read_data_Ack;

  // master: the core issuing ops plus the memory answering them
  modport master (
    output op_valid, op_write, op_size, op_unsigned, op_addr, op_wdata,
    output Mem_Req_Ack, Read_data, Read_data_Valid,
    input  op_ready, done, err, rdata,
    input  Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack
  );

  modport slave (
    input  op_valid, op_write, op_size, op_unsigned, op_addr, op_wdata,
    input  Mem_Req_Ack, Read_data, Read_data_Valid,
    output op_ready, done, err, rdata,
    output Address, MemWrite, MemRead, Write_data, Write_strb, Read_data_Ack
  );
endinterface

// File: rtl/mem_handshake_ctrl.sv
// rtl/mem_handshake_ctrl.sv - load/store handshake sequencer with lane steering and load extension
// Optional hung-memory abort enabled by defining MEM_TIMEOUT_EN.
module mem_handshake_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_handshake_ctrl_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);

  typedef enum logic [2:0] {S_IDLE, S_LD, S_RDW, S_ST, S_DONE} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic                err_q;

  logic                accept, illegal, time_up, awaited, abort;
  logic [LANE_W-1:0]   op_lane, lane_q;
  logic [STRB_W-1:0]   op_strb;
  logic [DATA_W-1:0]   ld_shift, ld_mask, ld_ext;
  logic                ld_msb;

  assign accept  = (state == S_IDLE) && bus.op_valid;
  assign op_lane = bus.op_addr[LANE_W-1:0];
  assign lane_q  = addr_q[LANE_W-1:0];

  assign illegal = (bus.op_size == 2'd1 && bus.op_addr[0]) ||
                   (bus.op_size == 2'd2 && bus.op_addr[1:0] != 2'b00) ||
                   (bus.op_size == 2'd3 && (bus.op_addr[2:0] != 3'b000 || DATA_W == 32));

  always_comb begin
    op_strb = '0;
    case (bus.op_size)
      2'd0:    op_strb = STRB_W'(8'h01) << op_lane;
      2'd1:    op_strb = STRB_W'(8'h03) << op_lane;
      2'd2:    op_strb = STRB_W'(8'h0F) << op_lane;
      default: op_strb = '1;
    endcase
  end

  // Load data: shift the addressed lane down, then mask and extend.
  always_comb begin
    ld_shift = bus.Read_data >> {lane_q, 3'b000};
    ld_mask  = '1;
    ld_msb   = 1'b0;
    case (size_q)
      2'd0:    begin ld_mask = DATA_W'(8'hFF);         ld_msb = ld_shift[7];  end
      2'd1:    begin ld_mask = DATA_W'(16'hFFFF);      ld_msb = ld_shift[15]; end
      2'd2:    begin ld_mask = DATA_W'(32'hFFFF_FFFF); ld_msb = ld_shift[31]; end
      default: begin ld_mask = '1;                     ld_msb = 1'b0;         end
    endcase
    ld_ext = (ld_shift & ld_mask) | ((!uns_q && ld_msb) ? ~ld_mask : '0);
  end

  assign awaited = (state == S_RDW) ? bus.Read_data_Valid : bus.Mem_Req_Ack;
  assign abort   = time_up && !awaited;

`ifdef MEM_TIMEOUT_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      wait_cnt <= '0;
    else if (state_next != state)
      wait_cnt <= '0;
    else if (state == S_LD || state == S_RDW || state == S_ST)
      wait_cnt <= wait_cnt + 16'd1;
  end

  // Fires on the last permitted wait cycle; an ack in that cycle still wins.
  assign time_up = (state == S_LD || state == S_RDW || state == S_ST) &&
                   (wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = |16'(TIMEOUT_CYC);
  assign time_up = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = illegal ? S_DONE : (bus.op_write ? S_ST : S_LD);
      S_LD:   if (bus.Mem_Req_Ack) state_next = S_RDW;
              else if (abort) state_next = S_DONE;
      S_RDW:  if (bus.Read_data_Valid || abort) state_next = S_DONE;
      S_ST:   if (bus.Mem_Req_Ack || abort) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      strb_q  <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= bus.op_addr;
      size_q  <= bus.op_size;
      uns_q   <= bus.op_unsigned;
      wdata_q <= bus.op_wdata << {op_lane, 3'b000};
      strb_q  <= op_strb;
      rdata_q <= '0;
      err_q   <= illegal;
    end else if (state == S_RDW && bus.Read_data_Valid) begin
      rdata_q <= ld_ext;
    end else if (abort) begin
      err_q   <= 1'b1;
    end
  end

  assign bus.op_ready      = (state == S_IDLE);
  assign bus.done          = (state == S_DONE);
  assign bus.err           = (state == S_DONE) && err_q;
  assign bus.rdata         = rdata_q;
  assign bus.Address       = addr_q;
  assign bus.MemRead       = (state == S_LD);
  assign bus.MemWrite      = (state == S_ST);
  assign bus.Read_data_Ack = (state == S_RDW);
  assign bus.Write_data    = wdata_q;
  assign bus.Write_strb    = (state == S_ST) ? strb_q : '0;
endmodule
